wav_stream_arbiter: RTL and testbench
=====================================

WAV_STREAM_ARBITER -- requirements
Module: wav_stream_arbiter

Interface
REQ-001 Parameters SHALL be as follows (one per line: name, default, meaning).
- N, 4, number of requesting stream sources (2..16).
- DW, 8, stream data width.
- BURST, 4, maximum transfers per grant (1..256).
REQ-002 Ports SHALL be as follows (one per line: name, direction, width, meaning).
- clk, in, 1, single clock, all logic rising-edge.
- rst, in, 1, asynchronous active-low reset.
- ctl_en, in, 1, enable for new grants.
- s_tvalid, in, N, per-source valid.
- s_tready, out, N, per-source ready.
- s_tdata, in, N*DW, per-source data, source i at bits [i*DW +: DW].
- m_tvalid, out, 1, shared drain valid.
- m_tready, in, 1, shared drain ready.
- m_tdata, out, DW, shared drain data.
- sts_busy, out, 1, grant held.
- sts_gnt, out, $clog2(N), index of the granted source.
REQ-003 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-low.

Function
REQ-004 The state machine SHALL have two states: IDLE and GRANT.
REQ-005 In IDLE with ctl_en=1 and any s_tvalid set, the block SHALL register a grant to the first requester at or after ptr, round-robin order ascending with wrap N-1 -> 0, and move to GRANT on the next edge.
REQ-006 Arbitration latency SHALL be one cycle: the first m_tvalid is seen no earlier than the cycle after the request.
REQ-007 In GRANT, the drain path SHALL be combinational from the granted source:
- m_tvalid = s_tvalid[gnt];
- m_tdata = s_tdata[gnt];
- s_tready[gnt] = m_tready.
REQ-008 In GRANT, all other s_tready bits SHALL be 0; in IDLE, all s_tready bits SHALL be 0, m_tvalid SHALL be 0 and m_tdata SHALL be 0.
REQ-009 A transfer SHALL be counted when m_tvalid and m_tready are both 1; the burst counter SHALL be 8 bits, SHALL clear on each new grant, and SHALL increment per transfer.
REQ-010 GRANT SHALL return to IDLE on the edge after the BURST-th transfer.
REQ-011 GRANT SHALL return to IDLE on any edge where s_tvalid[gnt]=0 (source went idle).
REQ-012 On leaving GRANT, ptr SHALL become gnt+1 modulo N.
REQ-013 ctl_en=0 SHALL block new grants only; a grant in progress SHALL finish per REQ-010/011.
REQ-014 If the granted source and others request simultaneously at release, the next grant SHALL go to the lowest index above the released one.
REQ-015 A source SHALL never lose a grant while its beat is pending: while s_tvalid[gnt]=1 and m_tready=0, the block SHALL stay in GRANT.
REQ-016 sts_busy SHALL be 1 exactly in GRANT; sts_gnt SHALL hold the last granted index.

Reset
REQ-017 While rst=0, the block SHALL set state=IDLE, ptr=0, burst counter=0 and sts_gnt=0, and all outputs SHALL read 0, immediately and asynchronously.
REQ-018 Reset asserted mid-burst SHALL abort the burst; no transfer SHALL complete on the reset edge.

Configuration
REQ-019 With WAV_STREAM_ARBITER_CNT_EN defined, the block SHALL add output sts_cnt [16]:
- counts all drain transfers;
- wraps 16'hFFFF -> 0;
- reset value 0.
REQ-020 Without WAV_STREAM_ARBITER_CNT_EN, neither sts_cnt nor its logic SHALL exist.

Structure
REQ-021 Package wav_stream_pkg SHALL hold:
- the state enum (IDLE, GRANT);
- the defaults for DW, N and BURST;
- the burst counter width constant (8).
REQ-022 Round-robin selection SHALL live in a combinational sub-module, wav_stream_rr_pick (inputs req[N] and ptr; outputs idx and any).

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Reset, then ctl_en=1 and s_tvalid=4'b0001 with m_tready=1: the first m_tvalid appears 1 cycle after the request, source 0 data passes through, and after 4 transfers the block re-grants source 0 after 1 IDLE cycle.
- s_tvalid=4'b1111 held with m_tready=1 and BURST=4: the grant order is 0,1,2,3,0, each grant is exactly 4 transfers, and sts_gnt follows.
- Grant to 2 with m_tready=0 for 5 cycles: sts_busy stays 1, s_tready=0, and m_tdata is stable.
- Source 1 drops s_tvalid after 2 transfers: the block is in IDLE next cycle and ptr=2.
- ctl_en=0 during a grant: the burst completes, then the block stays in IDLE with m_tvalid=0.
- rst=0 asserted mid-burst: all outputs read 0 at once; after release, ptr=0 and the first grant goes to the lowest requester.
- With WAV_STREAM_ARBITER_CNT_EN defined: after 65537 transfers, sts_cnt=1.

Source files
------------

// File: rtl/wav_stream_pkg.sv
// Shared definitions for the stream arbiter: FSM state type, parameter
// defaults and the burst counter width.
package wav_stream_pkg;

   localparam int DEF_N      = 4;
   localparam int DEF_DW     = 8;
   localparam int DEF_BURST  = 4;
   localparam int BCNT_W     = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/wav_stream_arbiter_if.sv
// Stream bundle between N sources and one shared drain.
// The arbiter connects through the slave modport; the environment uses master.
interface wav_stream_arbiter_if
   import wav_stream_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int DW = DEF_DW
);

   logic [N-1:0]    s_tvalid;
   logic [N-1:0]    s_tready;
   logic [N*DW-1:0] s_tdata;
   logic            m_tvalid;
   logic            m_tready;
   logic [DW-1:0]   m_tdata;

   modport slave (
      input  s_tvalid, s_tdata, m_tready,
      output s_tready, m_tvalid, m_tdata
   );

   modport master (
      output s_tvalid, s_tdata, m_tready,
      input  s_tready, m_tvalid, m_tdata
   );

endinterface

// File: rtl/wav_stream_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping to the lowest set bit when nothing at or above ptr requests.
module wav_stream_rr_pick #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [N-1:0] hi_req;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise an unassigned path infers a latch.
      hi_req = '0;
      for (int i = 0; i < N; i++) begin
         hi_req[i] = req[i] && (IW'(i) >= ptr);
      end
   end

   always_comb begin
      // NOTE: combinational logic uses blocking '=' so later statements see
      // earlier results; the descending loop leaves the lowest match in idx.
      idx = '0;
      any = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if ((|hi_req) ? hi_req[i] : req[i]) begin
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/wav_stream_arbiter.sv
// Round-robin N:1 stream arbiter with bounded bursts per grant.
// Optional WAV_STREAM_ARBITER_CNT_EN adds a 16-bit total transfer counter.
module wav_stream_arbiter
   import wav_stream_pkg::*;
#(
   parameter  int N     = DEF_N,
   parameter  int DW    = DEF_DW,
   parameter  int BURST = DEF_BURST,
   localparam int IW    = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ctl_en,
   wav_stream_arbiter_if.slave  bus,
   output logic                 sts_busy,
   output logic [IW-1:0]        sts_gnt
`ifdef WAV_STREAM_ARBITER_CNT_EN
   ,
   output logic [15:0]          sts_cnt
`endif
);

   localparam logic [BCNT_W:0] BURST_LEN = (BCNT_W + 1)'(BURST);

   state_e              state;
   logic [IW-1:0]       gnt;
   logic [IW-1:0]       ptr;
   logic [BCNT_W-1:0]   bcnt;

   logic [IW-1:0]       pick_idx;
   logic                pick_any;
   logic                gnt_valid;
   logic                xfer;
   logic                last_beat;
   logic                release_now;
   logic [IW-1:0]       next_ptr;

   wav_stream_rr_pick #(.N(N)) u_pick (
      .req (bus.s_tvalid),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign gnt_valid   = bus.s_tvalid[gnt];
   assign xfer        = (state == GRANT) && gnt_valid && bus.m_tready;
   assign last_beat   = ({1'b0, bcnt} + 1'b1) == BURST_LEN;
   // A stalled beat (valid high, ready low) never releases the grant.
   assign release_now = (state == GRANT) && (!gnt_valid || (xfer && last_beat));
   assign next_ptr    = (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;

   assign sts_busy = (state == GRANT);
   assign sts_gnt  = gnt;

   always_comb begin
      bus.s_tready = '0;
      bus.m_tvalid = 1'b0;
      bus.m_tdata  = '0;
      if (state == GRANT) begin
         bus.m_tvalid      = gnt_valid;
         bus.m_tdata       = bus.s_tdata[gnt*DW +: DW];
         bus.s_tready[gnt] = bus.m_tready;
      end
   end

   // NOTE: sequential state uses non-blocking '<=' and every register is
   // cleared by the asynchronous reset, so outputs drop to 0 the moment rst falls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         bcnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ctl_en && pick_any) begin
                  state <= GRANT;
                  gnt   <= pick_idx;
                  bcnt  <= '0;
               end
            end
            GRANT: begin
               if (xfer) begin
                  bcnt <= bcnt + 1'b1;
               end
               if (release_now) begin
                  state <= IDLE;
                  ptr   <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WAV_STREAM_ARBITER_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sts_cnt <= '0;
      end else if (xfer) begin
         sts_cnt <= sts_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_wav_stream_arbiter.sv
// Self-checking bench for wav_stream_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_wav_stream_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int BURST = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ctl_en = 1'b0;
   logic       sts_busy;
   logic [1:0] sts_gnt;
   logic [7:0] dat [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wav_stream_arbiter_if #(.N(N), .DW(DW)) bus ();

`ifdef WAV_STREAM_ARBITER_CNT_EN
   logic [15:0] sts_cnt;
   logic        ctl2 = 1'b0;
   logic        busy2;
   logic [1:0]  gnt2;
   logic [15:0] cnt2;
   wav_stream_arbiter_if #(.N(N), .DW(DW)) bus2 ();

   wav_stream_arbiter #(.N(N), .DW(DW), .BURST(256)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .ctl_en   (ctl2),
      .bus      (bus2),
      .sts_busy (busy2),
      .sts_gnt  (gnt2),
      .sts_cnt  (cnt2)
   );
`endif

   wav_stream_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
      .clk      (clk),
      .rst      (rst),
      .ctl_en   (ctl_en),
      .bus      (bus),
      .sts_busy (sts_busy),
      .sts_gnt  (sts_gnt)
`ifdef WAV_STREAM_ARBITER_CNT_EN
      ,
      .sts_cnt  (sts_cnt)
`endif
   );

   typedef struct {
      logic       ctl;
      logic [3:0] v;
      logic       r;
      logic       busy;
      logic [1:0] g;
      logic       mv;
      logic [3:0] tr;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_data();
      bus.s_tdata = {dat[3], dat[2], dat[1], dat[0]};
   endtask

   task automatic check_outs(input string tag, input logic eb, input logic [1:0] eg,
                             input logic emv, input logic [3:0] etr);
      logic [7:0] emd;
      emd = eb ? dat[eg] : 8'h00;
      check({tag, ".busy"},   32'(sts_busy),     32'(eb));
      check({tag, ".gnt"},    32'(sts_gnt),      32'(eg));
      check({tag, ".mvalid"}, 32'(bus.m_tvalid), 32'(emv));
      check({tag, ".mdata"},  32'(bus.m_tdata),  32'(emd));
      check({tag, ".sready"}, 32'(bus.s_tready), 32'(etr));
   endtask

   task automatic drive(input logic c, input logic [3:0] v, input logic r);
      @(negedge clk);
      ctl_en       = c;
      bus.s_tvalid = v;
      bus.m_tready = r;
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst          = 1'b0;
      ctl_en       = 1'b0;
      bus.s_tvalid = '0;
      bus.m_tready = 1'b0;
      #1;
      check_outs({tag, ".rst"}, 1'b0, 2'd0, 1'b0, 4'b0000);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Behavioural model state for the randomized run.
   bit         m_busy;
   int         m_g, m_p, m_beats, m_xfers;

   initial begin
      logic [3:0] rv;
      logic       rr, rc;
      int         c, cnt;

      for (int i = 0; i < N; i++) dat[i] = 8'hA0 + 8'(i * 17);
      set_data();
      bus.s_tvalid = '0;
      bus.m_tready = 1'b0;
`ifdef WAV_STREAM_ARBITER_CNT_EN
      bus2.s_tvalid = 4'b1111;
      bus2.s_tdata  = '0;
      bus2.m_tready = 1'b0;
`endif

      // Single requester: one-cycle latency, burst of 4, one IDLE cycle, re-grant.
      tbl[0] = '{1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
      for (int k = 1; k <= 4; k++) tbl[k] = '{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
      tbl[5] = '{1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[6] = '{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};

      #1;
      check_outs("por", 1'b0, 2'd0, 1'b0, 4'b0000);
      do_reset("s1");
      for (int k = 0; k < 7; k++) begin
         drive(tbl[k].ctl, tbl[k].v, tbl[k].r);
         check_outs($sformatf("s1.c%0d", k), tbl[k].busy, tbl[k].g, tbl[k].mv, tbl[k].tr);
      end

      // All four requesting: order 0,1,2,3,0, four beats each.
      do_reset("s2");
      for (int k = 0; k < 22; k++) begin
         logic       eb;
         logic [1:0] eg;
         eb = (k % 5) != 0;
         eg = (k == 0) ? 2'd0 : 2'((((k - 1) / 5)) % 4);
         drive(1'b1, 4'b1111, 1'b1);
         check_outs($sformatf("s2.c%0d", k), eb, eg, eb, eb ? 4'(1 << eg) : 4'b0000);
      end

      // Grant to 2 stalled by m_tready=0 for five cycles, then drained.
      do_reset("s3");
      drive(1'b1, 4'b0100, 1'b0);
      check_outs("s3.idle", 1'b0, 2'd0, 1'b0, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 4'b0100, 1'b0);
         check_outs($sformatf("s3.stall%0d", k), 1'b1, 2'd2, 1'b1, 4'b0000);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 4'b0100, 1'b1);
         check_outs($sformatf("s3.beat%0d", k), 1'b1, 2'd2, 1'b1, 4'b0100);
      end
      drive(1'b1, 4'b0100, 1'b1);
      check_outs("s3.rel", 1'b0, 2'd2, 1'b0, 4'b0000);

      // Source 1 goes idle after two beats: IDLE next cycle, then ptr=2.
      do_reset("s4");
      drive(1'b1, 4'b0010, 1'b1);
      check_outs("s4.idle", 1'b0, 2'd0, 1'b0, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 4'b0010, 1'b1);
         check_outs($sformatf("s4.beat%0d", k), 1'b1, 2'd1, 1'b1, 4'b0010);
      end
      drive(1'b1, 4'b0000, 1'b1);
      check_outs("s4.drop", 1'b1, 2'd1, 1'b0, 4'b0010);
      drive(1'b1, 4'b1111, 1'b1);
      check_outs("s4.after", 1'b0, 2'd1, 1'b0, 4'b0000);
      drive(1'b1, 4'b1111, 1'b1);
      check_outs("s4.next", 1'b1, 2'd2, 1'b1, 4'b0100);

      // ctl_en dropped mid-grant: burst completes, no new grant.
      do_reset("s5");
      drive(1'b1, 4'b0001, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 4'b0001, 1'b1);
         check_outs($sformatf("s5.beat%0d", k), 1'b1, 2'd0, 1'b1, 4'b0001);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 4'b0001, 1'b1);
         check_outs($sformatf("s5.held%0d", k), 1'b0, 2'd0, 1'b0, 4'b0000);
      end
      drive(1'b1, 4'b0001, 1'b1);
      drive(1'b1, 4'b0001, 1'b1);
      check_outs("s5.resume", 1'b1, 2'd0, 1'b1, 4'b0001);

      // Reset mid-burst: outputs clear at once, ptr restarts at 0.
      do_reset("s6");
      drive(1'b1, 4'b0100, 1'b1);
      drive(1'b1, 4'b0100, 1'b1);
      check_outs("s6.gnt", 1'b1, 2'd2, 1'b1, 4'b0100);
      @(negedge clk);
      bus.s_tvalid = 4'b1111;
      #1;
      rst = 1'b0;
      #1;
      check_outs("s6.async", 1'b0, 2'd0, 1'b0, 4'b0000);
`ifdef WAV_STREAM_ARBITER_CNT_EN
      check("s6.cnt", 32'(sts_cnt), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outs("s6.idle", 1'b0, 2'd0, 1'b0, 4'b0000);
      drive(1'b1, 4'b1111, 1'b1);
      check_outs("s6.first", 1'b1, 2'd0, 1'b1, 4'b0001);

      // Randomized run against the behavioural model.
      do_reset("rnd");
      m_busy = 0; m_g = 0; m_p = 0; m_beats = 0; m_xfers = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            rv[i]  = ($urandom_range(0, 7) != 0);
            dat[i] = 8'($urandom);
         end
         rr = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 3) != 0);
         ctl_en       = rc;
         bus.s_tvalid = rv;
         bus.m_tready = rr;
         set_data();
         #1;
         check_outs($sformatf("rnd.c%0d", cyc), m_busy, 2'(m_g),
                    m_busy ? rv[m_g] : 1'b0,
                    (m_busy && rr) ? 4'(1 << m_g) : 4'b0000);
         if (m_busy) begin
            if (rv[m_g] && rr) begin
               m_beats++;
               m_xfers++;
            end
            if (!rv[m_g] || m_beats == BURST) begin
               m_busy = 0;
               m_p    = (m_g + 1) % N;
            end
         end else if (rc && rv != 4'b0000) begin
            for (int k = 0; k < N; k++) begin
               if (!m_busy && rv[(m_p + k) % N]) begin
                  m_g    = (m_p + k) % N;
                  m_busy = 1;
               end
            end
            m_beats = 0;
         end
      end
`ifdef WAV_STREAM_ARBITER_CNT_EN
      @(negedge clk);
      ctl_en = 1'b0;
      bus.m_tready = 1'b0;
      #1;
      check("rnd.cnt", 32'(sts_cnt), 32'(16'(m_xfers)));

      // 65537 transfers through a BURST=256 instance wrap the counter to 1.
      do_reset("cnt");
      c   = 0;
      cnt = 0;
      while (cnt < 65537) begin
         @(negedge clk);
         ctl2          = 1'b1;
         bus2.m_tready = 1'b1;
         if (c % 257 != 0) cnt++;
         c++;
      end
      @(negedge clk);
      bus2.m_tready = 1'b0;
      #1;
      check("cnt.wrap", 32'(cnt2), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
